// File: rtl/sa_skew_feeder_if.sv
// Producer-side handshake and array-side lane bus of the systolic-array skew feeder.
// The master is the vector producer (which also observes the array-facing outputs); the slave is the feeder.
interface sa_skew_feeder_if #(
  parameter int NUM_ROWS   = 8,
  parameter int NUM_COLS   = 4,
  parameter int DATA_WIDTH = 8
);
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_ROWS*DATA_WIDTH-1:0] in_act;
  logic [NUM_COLS*DATA_WIDTH-1:0] in_wgt;
  logic                           in_last;
  logic                           arr_clear;
  logic [NUM_ROWS*DATA_WIDTH-1:0] act_out;
  logic [NUM_COLS*DATA_WIDTH-1:0] wgt_out;
  logic                           arr_valid;
  logic                           tile_done;
  logic                           busy;

  modport master (
    output in_valid, in_act, in_wgt, in_last,
    input  in_ready, arr_clear, act_out, wgt_out, arr_valid, tile_done, busy
  );

  modport slave (
    input  in_valid, in_act, in_wgt, in_last,
    output in_ready, arr_clear, act_out, wgt_out, arr_valid, tile_done, busy
  );
endinterface

// File: rtl/sa_skew_feeder.sv
// Tile buffer plus diagonal-skew lane driver for the NUM_ROWS x NUM_COLS systolic MAC array.
// Buffers up to DEPTH vectors, pulses the accumulator clear, then streams the tile with lane r / c delayed r / c cycles.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   LOAD   | accept vectors into the tile buffer until in_last or full
//   CLEAR  | one-cycle accumulator clear; buffer word 0 enters the skew chains
//   STREAM | K cycles; remaining buffer words enter the skew chains
//   DRAIN  | M-1 cycles of zeros flushing the longest skew chain
//   DONE   | one-cycle tile_done pulse, buffer emptied
module sa_skew_feeder #(
  parameter int NUM_ROWS   = 8,
  parameter int NUM_COLS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input logic             clk,
  input logic             reset,
  sa_skew_feeder_if.slave bus
);

  localparam int M  = (NUM_ROWS > NUM_COLS) ? NUM_ROWS : NUM_COLS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int TW = (AW > MW) ? AW : MW;
  localparam int AV = NUM_ROWS * DATA_WIDTH;
  localparam int WV = NUM_COLS * DATA_WIDTH;

  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
  localparam logic [TW-1:0] DRAIN_INIT = TW'((M > 1) ? (M - 2) : 0);

  localparam logic [2:0] LOAD   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] count;
  logic [AW-1:0] klast;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] tmr;

  logic in_ready_q;
  logic arr_clear_q;
  logic arr_valid_q;
  logic tile_done_q;
  logic busy_q;

  logic accept;
  logic tile_end;
  logic head_en;

  logic [AV-1:0] act_mem [DEPTH];
  logic [WV-1:0] wgt_mem [DEPTH];
  logic [AV-1:0] head_act;
  logic [WV-1:0] head_wgt;

  // in_ready_q is high exactly while in LOAD, so it doubles as the accept qualifier.
  assign accept   = bus.in_valid && in_ready_q;
  assign tile_end = accept && (bus.in_last || (count == LAST_IDX));

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (tile_end) state_nxt = CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if (tmr == '0) state_nxt = (M > 1) ? DRAIN : DONE;
      DRAIN:   if (tmr == '0) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= LOAD;
      count  <= '0;
      klast  <= '0;
      rd_ptr <= '0;
      tmr    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          rd_ptr <= '0;
          if (accept) count <= count + 1'b1;
          if (tile_end) klast <= count;
        end
        CLEAR: begin
          tmr    <= TW'(klast);
          rd_ptr <= rd_ptr + 1'b1;
        end
        STREAM: begin
          rd_ptr <= rd_ptr + 1'b1;
          if (tmr == '0) tmr <= DRAIN_INIT;
          else           tmr <= tmr - 1'b1;
        end
        DRAIN: begin
          if (tmr != '0) tmr <= tmr - 1'b1;
        end
        DONE: begin
          count  <= '0;
          rd_ptr <= '0;
        end
        default: begin
          count  <= '0;
          rd_ptr <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q  <= 1'b1;
      arr_clear_q <= 1'b0;
      arr_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_nxt == LOAD);
      arr_clear_q <= (state_nxt == CLEAR);
      arr_valid_q <= (state_nxt == STREAM) || (state_nxt == DRAIN);
      tile_done_q <= (state_nxt == DONE);
      busy_q      <= (state_nxt != LOAD);
    end
  end

  // Data storage needs no reset: count alone defines which words are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      act_mem[count] <= bus.in_act;
      wgt_mem[count] <= bus.in_wgt;
    end
  end

  // The chain head loads one cycle ahead of the visible lane so word t shows on lane 0 at s = t.
  assign head_en = (state == CLEAR) || ((state == STREAM) && (tmr != '0));

  always_comb begin
    head_act = '0;
    head_wgt = '0;
    if (head_en) begin
      head_act = act_mem[rd_ptr];
      head_wgt = wgt_mem[rd_ptr];
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_act
    logic [DATA_WIDTH-1:0] pipe [r+1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i <= r; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= head_act[r*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i <= r; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign bus.act_out[r*DATA_WIDTH +: DATA_WIDTH] = pipe[r];
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_wgt
    logic [DATA_WIDTH-1:0] pipe [c+1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i <= c; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= head_wgt[c*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i <= c; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign bus.wgt_out[c*DATA_WIDTH +: DATA_WIDTH] = pipe[c];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.arr_clear = arr_clear_q;
  assign bus.arr_valid = arr_valid_q;
  assign bus.tile_done = tile_done_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/sa_skew_feeder.md
# sa_skew_feeder

Input staging stage directly upstream of the 8x4 systolic MAC array. It accepts one activation vector (one byte per array row) plus one weight vector (one byte per array column) per handshake and buffers a tile of up to DEPTH vectors. It then issues a one-cycle accumulator-clear pulse and streams the tile into the array with diagonal skew: row lane r is delayed r cycles, column lane c is delayed c cycles. Zeros fill all lanes outside the valid window.

## Interface
- NUM_ROWS, 8, activation lanes (array rows)
- NUM_COLS, 4, weight lanes (array columns)
- DATA_WIDTH, 8, bits per lane, signed two's complement, passed bit-exact
- DEPTH, 8, max vectors per tile (K); buffer depth
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- in_valid  in  1  producer has a vector
- in_ready  out  1  feeder can accept; transfer when in_valid && in_ready at rising edge
- in_act  in  NUM_ROWS*DATA_WIDTH  activation vector, lane r = bits [r*DW +: DW]
- in_wgt  in  NUM_COLS*DATA_WIDTH  weight vector, lane c = bits [c*DW +: DW]
- in_last  in  1  qualifies the final vector of the tile
- arr_clear  out  1  one-cycle pulse driving the array's accumulator reset
- act_out  out  NUM_ROWS*DATA_WIDTH  skewed activations to the array's column-0 inputs
- wgt_out  out  NUM_COLS*DATA_WIDTH  skewed weights to the array's row-0 inputs
- arr_valid  out  1  high while any skew window is open
- tile_done  out  1  one-cycle pulse after the last skewed element leaves
- busy  out  1  high in every state except LOAD

## Operation
- States: LOAD -> CLEAR -> STREAM -> DRAIN -> DONE -> LOAD.
- LOAD:
  - in_ready = (count < DEPTH).
  - Each accepted vector is written to buf[count], then count increments.
  - Exit to CLEAR when the accepted vector has in_last = 1, or when the accept brings count to DEPTH (implicit last).
  - K = count after that final accept, so 1 <= K <= DEPTH.
- CLEAR: arr_clear = 1 for exactly one cycle. Lane outputs stay 0.
- STREAM: K cycles, with t = 0..K-1. Vector buf[t] enters the head of the skew chains.
- DRAIN: M-1 cycles, where M = max(NUM_ROWS, NUM_COLS). Zeros enter the skew chains.
- DONE: tile_done = 1 for one cycle. count resets to 0, then the block returns to LOAD.
- Skew rule, with s = cycles since STREAM entry:
  - act_out lane r = buf[s-r].act[r] when 0 <= s-r < K, else 0.
  - wgt_out lane c = buf[s-c].wgt[c] when 0 <= s-c < K, else 0.
- arr_valid is high for exactly K+M-1 cycles, from s=0 through s=K+M-2.
- in_valid while in_ready = 0 is ignored; no data is captured.
- in_last is meaningful only on an accepted transfer.
- No arithmetic is performed; data is routed only.

## Timing
- Reset values: in_ready = 1 (state LOAD, count 0). All other outputs are 0: arr_clear, act_out, wgt_out, arr_valid, tile_done, busy. All skew registers are 0.
- Reset asserted mid-tile:
  - All outputs go to reset values asynchronously, without waiting for a clock edge.
  - The buffer is logically emptied; a partial tile is discarded.
  - The first accept after release is possible at the first rising edge where reset is high.
- Outputs are registered. With the final accept at edge E, "cycle n" means the n-th cycle after E:
  - cycle 1: arr_clear = 1, busy = 1, in_ready = 0.
  - cycle 2: s = 0; arr_valid = 1; act_out lane 0 = buf[0].act[0].
  - cycles 2 .. K+M: arr_valid = 1.
  - cycle K+M+1: tile_done = 1.
  - cycle K+M+2: LOAD; in_ready = 1, busy = 0.
- Back-to-back tiles: a new tile can be accepted starting at cycle K+M+2. No overlap between tiles.
- Simultaneous in_last with a full buffer: this is a single termination with K = DEPTH.

## Test plan
- Reset:
  - Stimulus: hold reset low, release, then assert reset low during STREAM of a K=3 tile.
  - Required response: in_ready = 1 and all other outputs 0 immediately on assertion. After release, a new tile is accepted normally.
- K=1:
  - Stimulus: in_act lanes 0x01..0x08, in_wgt lanes 0x11..0x14, in_last = 1.
  - Required response: arr_clear at cycle 1. act lane r = r+1 only at cycle 2+r. wgt lane c = 0x11+c only at cycle 2+c. arr_valid cycles 2..9. tile_done at cycle 10.
- K=4 with producer gaps:
  - Stimulus: in_valid with idle cycles between the four vectors.
  - Required response: timing is referenced to the last accept (arr_valid cycles 2..12, tile_done at 13). in_ready = 0 during cycles 1..13, and in_valid during that window is ignored.
- Full buffer:
  - Stimulus: 8 accepts with in_last = 0.
  - Required response: the 8th accept terminates the tile. in_ready drops in cycle 1. arr_valid is high for 15 cycles.
- Signed pass-through:
  - Stimulus: lanes 0x80 and 0xFF.
  - Required response: values appear bit-exact at the skewed cycles.
  - End-to-end: the feeder driving the array yields dot products matching a reference model, with accumulators cleared by arr_clear.
- Back-to-back tiles:
  - Stimulus: a second K=2 tile offered continuously.
  - Required response: first accept at cycle K+M+2 of the previous tile, with no stale data in any lane.
